poly_basemul_ctrl: RTL
======================

POLY_BASEMUL_CTRL -- requirements
Module: poly_basemul_ctrl

Interface
REQ-001 Parameter BM_LATENCY, default 12: cycles from the first WAIT cycle to a valid basemul result.
REQ-002 The block SHALL run on one clock and use an asynchronous, active-low reset.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to multiply a full polynomial pair; honoured only in IDLE.
REQ-006 abort  in  1  synchronous cancel; returns the block to IDLE.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse after the last result write.
REQ-009 rd_addr  out  7  coefficient-pair index p (0..127) for the a and b memories.
REQ-010 a_rd  in  2x16 signed  a[2p], a[2p+1]; valid one cycle after rd_addr is driven.
REQ-011 b_rd  in  2x16 signed  b[2p], b[2p+1]; same timing as a_rd.
REQ-012 zeta_addr  out  7  zeta ROM index; 1-cycle read latency.
REQ-013 zeta_rd  in  16 signed  zeta ROM data.
REQ-014 wr_en  out  1  result write strobe.
REQ-015 wr_addr  out  7  result pair index.
REQ-016 wr_data  out  2x16 signed  r[2p], r[2p+1].

Function
REQ-017 FSM states: IDLE, FETCH, LOAD, START, WAIT, WRITE, DONE.
REQ-018 IDLE: when start=1, clear pair counter p to 0 and go to FETCH; otherwise stay in IDLE.
REQ-019 FETCH: drive rd_addr=p and zeta_addr=64+(p>>1), then go to LOAD.
REQ-020 LOAD: register a_rd and b_rd; register zeta_rd if p is even, or its 16-bit two's-complement negation if p is odd; go to START.
REQ-021 START: assert the basemul start input for exactly one cycle; registered operands feed basemul; go to WAIT.
REQ-022 WAIT: last exactly BM_LATENCY cycles, counted by a down-counter; then go to WRITE.
REQ-023 Operand registers SHALL hold constant from LOAD through WRITE, because basemul samples a, b and zeta after start.
REQ-024 WRITE: wr_en=1 for one cycle, wr_addr=p, wr_data=basemul r; if p==127 go to DONE, else increment p and go to FETCH.
REQ-025 DONE: done=1 for one cycle, then go to IDLE.
REQ-026 Each pair SHALL take BM_LATENCY+4 cycles; done SHALL rise 128*(BM_LATENCY+4) cycles after the start edge.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 abort=1 in any non-IDLE state SHALL take the block to IDLE on the next edge; no further wr_en, no done.
REQ-029 abort SHALL take precedence over start and over any pending WRITE in the same cycle.
REQ-030 p SHALL never wrap; reaching 127 ends the run.
REQ-031 Coefficient and result arithmetic SHALL stay 16-bit signed, unreduced, exactly as produced by basemul.
REQ-032 -zeta SHALL NOT overflow, since |zeta| < 3329.

Reset
REQ-033 While rst_n=0: state=IDLE, p=0, and busy, done, wr_en, rd_addr, zeta_addr, wr_addr, wr_data and operand registers all 0.
REQ-034 Reset asserted mid-run SHALL abandon the run with no write, and no write in the cycle of reset release.
REQ-035 After reset release, a new start SHALL be accepted in the first cycle.

Structure
REQ-036 Package kyber_pkg SHALL hold KYBER_N=256, KYBER_Q=3329, NPAIRS=128, ZETA_BASE=64, the coef_t 16-bit signed type and the FSM state enum.
REQ-037 Exactly one basemul instance SHALL be the sole sub-module; memories and the zeta ROM are external.

Verification
REQ-038 All-zero a and b, start -> 128 writes, wr_addr 0..127 in order, all wr_data 0; done at cycle 2048 with BM_LATENCY=12.
REQ-039 Zeta sequencing -> zeta_addr 64,64,65,65,... for p=0,1,2,3; basemul zeta input = +zetas[64] at p=0 and -zetas[64] at p=1.
REQ-040 Random a and b in [-3328,3328] -> every wr_data pair matches a golden C Kyber basemul model bit-exactly.
REQ-041 start pulsed at p=10 and again at p=100 -> no restart; exactly 128 writes and one done.
REQ-042 abort asserted in WAIT of p=40 -> busy=0 next cycle; last write was p=39; no done; a following start runs the full 128 pairs.
REQ-043 rst_n pulsed low in WRITE of p=5 -> wr_en=0 immediately; all outputs 0; IDLE after release.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient type, controller state encoding and the
// Montgomery arithmetic used by the pair multiplier.
package kyber_pkg;

  localparam int KYBER_N   = 256;
  localparam int KYBER_Q   = 3329;
  localparam int NPAIRS    = KYBER_N / 2;
  localparam int ZETA_BASE = 64;
  localparam int QINV      = -3327;  // q^-1 mod 2^16, signed

  typedef logic signed [15:0] coef_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  // Returns a * 2^-16 mod q in the signed range (-q, q), not fully reduced.
  function automatic coef_t montgomery_reduce(input logic signed [31:0] a);
    logic signed [31:0] tq;
    coef_t              t;
    logic signed [31:0] u;
    tq = a * QINV;
    t  = tq[15:0];
    u  = a - 32'(t) * KYBER_Q;
    return u[31:16];
  endfunction

  function automatic coef_t fqmul(input coef_t a, input coef_t b);
    return montgomery_reduce(32'(a) * 32'(b));
  endfunction

  // Pairs 2k and 2k+1 share one zeta; the odd pair uses its negation.
  function automatic logic [6:0] zeta_index(input logic [6:0] p);
    return 7'(ZETA_BASE) + {1'b0, p[6:1]};
  endfunction

endpackage

// File: rtl/basemul.sv
// Degree-1 multiply in Z_q[X]/(X^2 - zeta): two registered stages, the first
// sampling the operands on start, the result valid two cycles after start.
module basemul
  import kyber_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  coef_t [1:0] a,
  input  coef_t [1:0] b,
  input  coef_t       zeta,
  output coef_t [1:0] r
);

  logic  s1_vld;
  coef_t p11, p00, p01, p10;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      p11    <= '0;
      p00    <= '0;
      p01    <= '0;
      p10    <= '0;
      r      <= '0;
    end else begin
      s1_vld <= start;
      if (start) begin
        p11 <= fqmul(a[1], b[1]);
        p00 <= fqmul(a[0], b[0]);
        p01 <= fqmul(a[0], b[1]);
        p10 <= fqmul(a[1], b[0]);
      end
      // Sums wrap in 16 bits, matching the unreduced reference arithmetic.
      if (s1_vld) begin
        r[0] <= fqmul(p11, zeta) + p00;
        r[1] <= p01 + p10;
      end
    end
  end

endmodule

// File: rtl/poly_basemul_ctrl.sv
// Sequences all 128 coefficient pairs of a polynomial pair through one basemul,
// fetching operands and zetas from external memories and writing results back.
module poly_basemul_ctrl
  import kyber_pkg::*;
#(
  parameter int BM_LATENCY = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [6:0]  rd_addr,
  input  coef_t [1:0] a_rd,
  input  coef_t [1:0] b_rd,
  output logic [6:0]  zeta_addr,
  input  coef_t       zeta_rd,
  output logic        wr_en,
  output logic [6:0]  wr_addr,
  output coef_t [1:0] wr_data
);

  localparam int         CW        = $clog2(BM_LATENCY + 1);
  localparam logic [6:0] LAST_PAIR = 7'(NPAIRS - 1);

  state_t      state;
  logic [6:0]  p;
  logic [CW-1:0] wait_cnt;
  coef_t [1:0] a_q, b_q;
  coef_t       zeta_q;
  logic        bm_start;
  coef_t [1:0] bm_r;

  basemul u_bm (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bm_start),
    .a     (a_q),
    .b     (b_q),
    .zeta  (zeta_q),
    .r     (bm_r)
  );

  // NOTE: all state and outputs use non-blocking assignment so every branch
  // reads the pre-edge values and the block has no ordering hazards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      p         <= '0;
      wait_cnt  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      zeta_q    <= '0;
      bm_start  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_en     <= 1'b0;
      rd_addr   <= '0;
      zeta_addr <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_en    <= 1'b0;
      done     <= 1'b0;
      bm_start <= 1'b0;
      // Abort wins over start and over the WAIT->WRITE transition.
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              p         <= '0;
              rd_addr   <= '0;
              zeta_addr <= zeta_index('0);
              busy      <= 1'b1;
              state     <= S_FETCH;
            end
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            a_q      <= a_rd;
            b_q      <= b_rd;
            zeta_q   <= p[0] ? -zeta_rd : zeta_rd;
            bm_start <= 1'b1;
            state    <= S_START;
          end
          S_START: begin
            wait_cnt <= CW'(BM_LATENCY - 1);
            state    <= S_WAIT;
          end
          S_WAIT: begin
            if (wait_cnt == '0) begin
              wr_en   <= 1'b1;
              wr_addr <= p;
              wr_data <= bm_r;
              state   <= S_WRITE;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end
          S_WRITE: begin
            if (p == LAST_PAIR) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              p         <= p + 7'd1;
              rd_addr   <= p + 7'd1;
              zeta_addr <= zeta_index(p + 7'd1);
              state     <= S_FETCH;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
